// File: rtl/imem_fetch_port.sv
// Pipelined instruction memory with valid/ready request and response channels,
// fault flagging, a program-load write port and a flush for branch redirects.
module imem_fetch_port #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 18,
    parameter int RD_LATENCY = 1,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [INST_WIDTH-1:0] resp_inst,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [1:0]            resp_err,
    input  logic                  flush,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [INST_WIDTH-1:0] ld_data
);

    localparam int FD = RD_LATENCY + 1;
    localparam int CW = $clog2(FD + 1);
    localparam int IW = $clog2(FD);
    localparam logic [CW-1:0] FD_C = CW'(FD);

    logic [INST_WIDTH-1:0] mem_q [0:(1 << DEPTH_LOG2)-1];

    logic [RD_LATENCY-1:0] p_valid_q;
    logic [INST_WIDTH-1:0] p_inst_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] p_addr_q [RD_LATENCY];
    logic [1:0]            p_err_q  [RD_LATENCY];

    logic [INST_WIDTH-1:0] fifo_inst_q [FD];
    logic [ADDR_WIDTH-1:0] fifo_addr_q [FD];
    logic [1:0]            fifo_err_q  [FD];
    logic [CW-1:0]         fifo_cnt_q;
    logic [CW-1:0]         fifo_cnt_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;

    logic [DEPTH_LOG2-1:0] rd_idx_s;
    logic [1:0]            req_err_s;
    logic                  req_fire_s;
    logic                  push_s;
    logic                  pop_s;
    logic [IW-1:0]         wr_idx_s;
    logic [INST_WIDTH-1:0] push_inst_s;

    assign rd_idx_s     = req_addr[DEPTH_LOG2+1:2];
    assign req_err_s[0] = (req_addr[1:0] != 2'b00);
    assign req_err_s[1] = |req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];

    // A departing response frees its slot in the same cycle, keeping full throughput.
    assign pop_s      = resp_valid & resp_ready;
    assign req_ready  = (cnt_q < FD_C) | pop_s | flush;
    assign req_fire_s = req_valid & req_ready & ~flush;
    assign push_s     = p_valid_q[RD_LATENCY-1] & ~flush;
    assign wr_idx_s   = IW'(pop_s ? (fifo_cnt_q - CW'(1)) : fifo_cnt_q);
    assign push_inst_s = (p_err_q[RD_LATENCY-1] != 2'b00) ? {INST_WIDTH{1'b0}}
                                                           : p_inst_q[RD_LATENCY-1];

    assign resp_valid = (fifo_cnt_q != {CW{1'b0}});
    assign resp_inst  = fifo_inst_q[0];
    assign resp_addr  = fifo_addr_q[0];
    assign resp_err   = fifo_err_q[0];

    // Memory write/read and data pipeline; non-blocking read gives read-before-write.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
        p_inst_q[0] <= mem_q[rd_idx_s];
        p_addr_q[0] <= req_addr;
        p_err_q[0]  <= req_err_s;
        for (int k = 1; k < RD_LATENCY; k++) begin
            p_inst_q[k] <= p_inst_q[k-1];
            p_addr_q[k] <= p_addr_q[k-1];
            p_err_q[k]  <= p_err_q[k-1];
        end
    end

    // Pipeline valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_q <= {RD_LATENCY{1'b0}};
        end else if (flush) begin
            p_valid_q <= {RD_LATENCY{1'b0}};
        end else begin
            p_valid_q[0] <= req_fire_s;
            for (int k = 1; k < RD_LATENCY; k++) begin
                p_valid_q[k] <= p_valid_q[k-1];
            end
        end
    end

    // Next-state for the buffer occupancy and the outstanding counter.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        cnt_d      = cnt_q;
        if (push_s && !pop_s) begin
            fifo_cnt_d = fifo_cnt_q + CW'(1);
        end else if (!push_s && pop_s) begin
            fifo_cnt_d = fifo_cnt_q - CW'(1);
        end else begin
            fifo_cnt_d = fifo_cnt_q;
        end
        if (flush) begin
            cnt_d = {CW{1'b0}};
        end else if (req_fire_s && !pop_s) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!req_fire_s && pop_s) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outstanding counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Shift-register response buffer: entry 0 is the head seen on resp_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt_q <= {CW{1'b0}};
            for (int i = 0; i < FD; i++) begin
                fifo_inst_q[i] <= {INST_WIDTH{1'b0}};
                fifo_addr_q[i] <= {ADDR_WIDTH{1'b0}};
                fifo_err_q[i]  <= 2'b00;
            end
        end else if (flush) begin
            fifo_cnt_q <= {CW{1'b0}};
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            if (pop_s) begin
                for (int i = 0; i < FD - 1; i++) begin
                    fifo_inst_q[i] <= fifo_inst_q[i+1];
                    fifo_addr_q[i] <= fifo_addr_q[i+1];
                    fifo_err_q[i]  <= fifo_err_q[i+1];
                end
            end
            if (push_s) begin
                fifo_inst_q[wr_idx_s] <= push_inst_s;
                fifo_addr_q[wr_idx_s] <= p_addr_q[RD_LATENCY-1];
                fifo_err_q[wr_idx_s]  <= p_err_q[RD_LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed self-checking bench for imem_fetch_port with RD_LATENCY=2.
module tb_imem_fetch_port;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic [31:0] resp_addr;
    logic [1:0]  resp_err;
    logic        flush;
    logic        ld_en;
    logic [17:0] ld_addr;
    logic [31:0] ld_data;

    int errors = 0;
    int checks = 0;

    imem_fetch_port #(
        .INST_WIDTH(32),
        .ADDR_WIDTH(32),
        .DEPTH_LOG2(18),
        .RD_LATENCY(2),
        .INIT_FILE("")
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_inst(resp_inst),
        .resp_addr(resp_addr),
        .resp_err(resp_err),
        .flush(flush),
        .ld_en(ld_en),
        .ld_addr(ld_addr),
        .ld_data(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic [31:0] inst,
                            input logic [31:0] addr, input logic [1:0] err);
        chk({tag, "_valid"}, {63'd0, resp_valid}, 64'd1);
        chk({tag, "_inst"},  {32'd0, resp_inst},  {32'd0, inst});
        chk({tag, "_addr"},  {32'd0, resp_addr},  {32'd0, addr});
        chk({tag, "_err"},   {62'd0, resp_err},   {62'd0, err});
    endtask

    task automatic load(input logic [17:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'd0; resp_ready = 1'b0;
        flush = 1'b0; ld_en = 1'b0; ld_addr = 18'd0; ld_data = 32'd0;
        #12;
        chk("rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_inst",  {32'd0, resp_inst},  64'd0);
        chk("rst_addr",  {32'd0, resp_addr},  64'd0);
        chk("rst_err",   {62'd0, resp_err},   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", {63'd0, req_ready}, 64'd1);

        load(18'd0, 32'h0050_0093);
        load(18'd1, 32'h0010_0113);
        load(18'd2, 32'h1111_1111);
        load(18'd3, 32'h2222_2222);
        load(18'd4, 32'h3333_3333);
        load(18'd5, 32'h5555_5555);

        // Back-to-back fetch, latency 2.
        resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
        tick();
        chk("lat_a0", {63'd0, resp_valid}, 64'd0);
        req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        chk("lat_a1", {63'd0, resp_valid}, 64'd0);
        tick();
        chk_resp("bb0", 32'h0050_0093, 32'h0, 2'b00);
        tick();
        chk_resp("bb1", 32'h0010_0113, 32'h4, 2'b00);
        tick();
        chk("bb_idle", {63'd0, resp_valid}, 64'd0);

        // Faults.
        req_valid = 1'b1; req_addr = 32'h6;
        tick();
        req_addr = 32'h0010_0000;
        tick();
        req_addr = 32'h0010_0002;
        tick();
        req_valid = 1'b0;
        chk_resp("mis", 32'h0, 32'h6, 2'b01);
        tick();
        chk_resp("oor", 32'h0, 32'h0010_0000, 2'b10);
        tick();
        chk_resp("both", 32'h0, 32'h0010_0002, 2'b11);
        tick();
        chk("flt_idle", {63'd0, resp_valid}, 64'd0);

        // Backpressure: exactly three accepted, outputs stable.
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_addr = 32'hC;
        tick();
        req_addr = 32'h10;
        tick();
        chk("stall_rdy0", {63'd0, req_ready}, 64'd0);
        req_addr = 32'h14;
        tick();
        chk("stall_rdy1", {63'd0, req_ready}, 64'd0);
        chk_resp("stall_h0", 32'h1111_1111, 32'h8, 2'b00);
        tick();
        chk_resp("stall_h1", 32'h1111_1111, 32'h8, 2'b00);
        req_valid = 1'b0; resp_ready = 1'b1;
        #1;
        chk("stall_rdy_back", {63'd0, req_ready}, 64'd1);
        tick();
        chk_resp("drain1", 32'h2222_2222, 32'hC, 2'b00);
        tick();
        chk_resp("drain2", 32'h3333_3333, 32'h10, 2'b00);
        tick();
        chk("drain_idle", {63'd0, resp_valid}, 64'd0);

        // Flush with three in flight plus a request in the flush cycle.
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        req_addr = 32'h8;
        tick();
        flush = 1'b1; req_addr = 32'hC;
        #1;
        chk("flush_rdy", {63'd0, req_ready}, 64'd1);
        tick();
        flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("flush_quiet", {63'd0, resp_valid}, 64'd0);
            tick();
        end
        req_valid = 1'b1; req_addr = 32'h10;
        tick();
        req_valid = 1'b0;
        chk("pf_a0", {63'd0, resp_valid}, 64'd0);
        tick();
        chk("pf_a1", {63'd0, resp_valid}, 64'd0);
        tick();
        chk_resp("post_flush", 32'h3333_3333, 32'h10, 2'b00);
        tick();
        chk("pf_idle", {63'd0, resp_valid}, 64'd0);

        // Load port read-before-write.
        req_valid = 1'b1; req_addr = 32'h14;
        ld_en = 1'b1; ld_addr = 18'd5; ld_data = 32'hDEAD_BEEF;
        tick();
        ld_en = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        chk_resp("ld_old", 32'h5555_5555, 32'h14, 2'b00);
        tick();
        chk_resp("ld_new", 32'hDEAD_BEEF, 32'h14, 2'b00);
        tick();
        chk("ld_idle", {63'd0, resp_valid}, 64'd0);

        // Async reset with two responses buffered.
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk_resp("pre_rst", 32'h0050_0093, 32'h0, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, resp_valid}, 64'd0);
        chk("arst_inst",  {32'd0, resp_inst},  64'd0);
        @(negedge clk);
        rst_n = 1'b1; resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_quiet", {63'd0, resp_valid}, 64'd0);
            chk("post_rst_rdy",   {63'd0, req_ready},  64'd1);
        end
        // Counter restarted at zero: three stalled accepts fill it exactly.
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
        tick();
        chk("pr_cnt1", {63'd0, req_ready}, 64'd1);
        tick();
        chk("pr_cnt2", {63'd0, req_ready}, 64'd1);
        tick();
        chk("pr_cnt3", {63'd0, req_ready}, 64'd0);
        req_valid = 1'b0;
        chk_resp("post_rst_mem", 32'h0010_0113, 32'h4, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
